// File: rtl/coll_det_param.sv
// Two-object collision detector: static separation test or continuous closest-approach test,
// computed with a single shared multiplier over a fixed 12-cycle schedule.
module coll_det_param #(
  parameter int W           = 16,
  parameter int RECEDE_MASK = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [W-1:0]     x1,
  input  logic [W-1:0]     y1,
  input  logic [W-1:0]     x2,
  input  logic [W-1:0]     y2,
  input  logic [W-1:0]     vx1,
  input  logic [W-1:0]     vy1,
  input  logic [W-1:0]     vx2,
  input  logic [W-1:0]     vy2,
  input  logic [2*W-1:0]   r2,
  input  logic             mode,
  input  logic             in_rdy,
  output logic             busy,
  output logic             out_rdy,
  output logic             hit,
  output logic             approaching,
  output logic [2*W+1:0]   sep_sq
);

  localparam int PW = 4*W + 4;   // wide arithmetic width
  localparam int OW = 2*W + 3;   // multiplier operand width, holds k with sign

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIFF,
    S_MUL,
    S_CMP,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            step_q, step_d;
  logic [W-1:0]          x1_q, y1_q, x2_q, y2_q, x1_d, y1_d, x2_d, y2_d;
  logic [W-1:0]          vx1_q, vy1_q, vx2_q, vy2_q, vx1_d, vy1_d, vx2_d, vy2_d;
  logic [2*W-1:0]        r2_q, r2_d;
  logic                  mode_q, mode_d;
  logic [W:0]            a_q, b_q, c_q, d_q, a_d, b_d, c_d, d_d;
  logic [2*W+1:0]        r_sq_q, r_sq_d, vab_sq_q, vab_sq_d;
  logic signed [OW-1:0]  k_q, k_d;
  logic signed [PW-1:0]  rv_q, rv_d, kk_q, kk_d, vr_q, vr_d;
  logic                  hit_pend_q, hit_pend_d, appr_pend_q, appr_pend_d;
  logic                  out_rdy_q, out_rdy_d;
  logic                  hit_q, hit_d, appr_q, appr_d;
  logic [2*W+1:0]        sep_sq_q, sep_sq_d;

  logic signed [OW-1:0]  mul_a, mul_b;
  logic signed [PW-1:0]  mul_a_x, mul_b_x, mul_p;

  logic                  static_lt, cont_lt, cont_hit;
  logic signed [PW-1:0]  cont_lhs;

  // Operand select for the shared multiplier, driven by the schedule step.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (state_q == S_MUL) begin
      case (step_q)
        4'd0: begin mul_a = OW'($signed(a_q)); mul_b = OW'($signed(a_q)); end
        4'd1: begin mul_a = OW'($signed(b_q)); mul_b = OW'($signed(b_q)); end
        4'd2: begin mul_a = OW'($signed(c_q)); mul_b = OW'($signed(c_q)); end
        4'd3: begin mul_a = OW'($signed(d_q)); mul_b = OW'($signed(d_q)); end
        4'd4: begin mul_a = OW'($signed(a_q)); mul_b = OW'($signed(c_q)); end
        4'd5: begin mul_a = OW'($signed(b_q)); mul_b = OW'($signed(d_q)); end
        4'd6: begin mul_a = $signed({1'b0, r_sq_q}); mul_b = $signed({1'b0, vab_sq_q}); end
        4'd7: begin mul_a = k_q; mul_b = k_q; end
        4'd8: begin mul_a = $signed({1'b0, vab_sq_q}); mul_b = $signed({3'b000, r2_q}); end
        default: begin mul_a = '0; mul_b = '0; end
      endcase
    end
  end

  assign mul_a_x = {{(PW-OW){mul_a[OW-1]}}, mul_a};
  assign mul_b_x = {{(PW-OW){mul_b[OW-1]}}, mul_b};
  assign mul_p   = mul_a_x * mul_b_x;

  assign static_lt = (r_sq_q < {2'b00, r2_q});
  assign cont_lhs  = rv_q - kk_q;
  assign cont_lt   = (cont_lhs < vr_q);

  always_comb begin
    cont_hit = (vab_sq_q == '0) ? static_lt : cont_lt;
    if (RECEDE_MASK != 0)
      cont_hit = cont_hit && (k_q[OW-1] || static_lt);
  end

  // Next-state and datapath updates; every register holds unless its state writes it.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    x1_d        = x1_q;
    y1_d        = y1_q;
    x2_d        = x2_q;
    y2_d        = y2_q;
    vx1_d       = vx1_q;
    vy1_d       = vy1_q;
    vx2_d       = vx2_q;
    vy2_d       = vy2_q;
    r2_d        = r2_q;
    mode_d      = mode_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    d_d         = d_q;
    r_sq_d      = r_sq_q;
    vab_sq_d    = vab_sq_q;
    k_d         = k_q;
    rv_d        = rv_q;
    kk_d        = kk_q;
    vr_d        = vr_q;
    hit_pend_d  = hit_pend_q;
    appr_pend_d = appr_pend_q;
    out_rdy_d   = 1'b0;
    hit_d       = hit_q;
    appr_d      = appr_q;
    sep_sq_d    = sep_sq_q;

    case (state_q)
      S_IDLE: begin
        if (in_rdy) begin
          state_d = S_DIFF;
          x1_d    = x1;
          y1_d    = y1;
          x2_d    = x2;
          y2_d    = y2;
          vx1_d   = vx1;
          vy1_d   = vy1;
          vx2_d   = vx2;
          vy2_d   = vy2;
          r2_d    = r2;
          mode_d  = mode;
        end
      end
      S_DIFF: begin
        a_d     = {x1_q[W-1], x1_q} - {x2_q[W-1], x2_q};
        b_d     = {y1_q[W-1], y1_q} - {y2_q[W-1], y2_q};
        c_d     = {vx1_q[W-1], vx1_q} - {vx2_q[W-1], vx2_q};
        d_d     = {vy1_q[W-1], vy1_q} - {vy2_q[W-1], vy2_q};
        step_d  = 4'd0;
        state_d = S_MUL;
      end
      S_MUL: begin
        case (step_q)
          4'd0: r_sq_d   = mul_p[2*W+1:0];
          4'd1: r_sq_d   = r_sq_q + mul_p[2*W+1:0];
          4'd2: vab_sq_d = mul_p[2*W+1:0];
          4'd3: vab_sq_d = vab_sq_q + mul_p[2*W+1:0];
          4'd4: k_d      = mul_p[OW-1:0];
          4'd5: k_d      = k_q + mul_p[OW-1:0];
          4'd6: rv_d     = mul_p;
          4'd7: kk_d     = mul_p;
          4'd8: vr_d     = mul_p;
          default: ;
        endcase
        if (step_q == 4'd8) begin
          state_d = S_CMP;
        end else begin
          step_d = step_q + 4'd1;
        end
      end
      S_CMP: begin
        hit_pend_d  = mode_q ? cont_hit : static_lt;
        appr_pend_d = k_q[OW-1];
        state_d     = S_DONE;
      end
      S_DONE: begin
        out_rdy_d = 1'b1;
        hit_d     = hit_pend_q;
        appr_d    = appr_pend_q;
        sep_sq_d  = r_sq_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset clears everything so an aborted request leaves no trace.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      x2_q        <= '0;
      y2_q        <= '0;
      vx1_q       <= '0;
      vy1_q       <= '0;
      vx2_q       <= '0;
      vy2_q       <= '0;
      r2_q        <= '0;
      mode_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      r_sq_q      <= '0;
      vab_sq_q    <= '0;
      k_q         <= '0;
      rv_q        <= '0;
      kk_q        <= '0;
      vr_q        <= '0;
      hit_pend_q  <= 1'b0;
      appr_pend_q <= 1'b0;
      out_rdy_q   <= 1'b0;
      hit_q       <= 1'b0;
      appr_q      <= 1'b0;
      sep_sq_q    <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      x2_q        <= x2_d;
      y2_q        <= y2_d;
      vx1_q       <= vx1_d;
      vy1_q       <= vy1_d;
      vx2_q       <= vx2_d;
      vy2_q       <= vy2_d;
      r2_q        <= r2_d;
      mode_q      <= mode_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      d_q         <= d_d;
      r_sq_q      <= r_sq_d;
      vab_sq_q    <= vab_sq_d;
      k_q         <= k_d;
      rv_q        <= rv_d;
      kk_q        <= kk_d;
      vr_q        <= vr_d;
      hit_pend_q  <= hit_pend_d;
      appr_pend_q <= appr_pend_d;
      out_rdy_q   <= out_rdy_d;
      hit_q       <= hit_d;
      appr_q      <= appr_d;
      sep_sq_q    <= sep_sq_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign out_rdy     = out_rdy_q;
  assign hit         = hit_q;
  assign approaching = appr_q;
  assign sep_sq      = sep_sq_q;

endmodule

// File: tb/tb_coll_det_param.sv
// Scoreboard bench for coll_det_param: a masked and an unmasked instance share all stimulus;
// expectations are queued at acceptance and retired on each out_rdy pulse.
module tb_coll_det_param;
  localparam int W = 16;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic signed [W-1:0] x1 = '0, y1 = '0, x2 = '0, y2 = '0;
  logic signed [W-1:0] vx1 = '0, vy1 = '0, vx2 = '0, vy2 = '0;
  logic [2*W-1:0] r2 = '0;
  logic mode = 1'b0, in_rdy = 1'b0;

  logic busy, out_rdy, hit, approaching;
  logic [2*W+1:0] sep_sq;
  logic busy_nm, out_rdy_nm, hit_nm, approaching_nm;
  logic [2*W+1:0] sep_sq_nm;

  typedef struct {
    logic        hit;
    logic        hit_nm;
    logic        appr;
    logic [33:0] sep;
    int          due;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  coll_det_param #(.W(W), .RECEDE_MASK(1)) dut (
    .clock(clock), .reset_n(reset_n),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .vx1(vx1), .vy1(vy1), .vx2(vx2), .vy2(vy2),
    .r2(r2), .mode(mode), .in_rdy(in_rdy),
    .busy(busy), .out_rdy(out_rdy), .hit(hit),
    .approaching(approaching), .sep_sq(sep_sq)
  );

  coll_det_param #(.W(W), .RECEDE_MASK(0)) dut_nm (
    .clock(clock), .reset_n(reset_n),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .vx1(vx1), .vy1(vy1), .vx2(vx2), .vy2(vy2),
    .r2(r2), .mode(mode), .in_rdy(in_rdy),
    .busy(busy_nm), .out_rdy(out_rdy_nm), .hit(hit_nm),
    .approaching(approaching_nm), .sep_sq(sep_sq_nm)
  );

  task automatic checkOutput(input string tag, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model at 68 bits so nothing can overflow for 16-bit inputs.
  function automatic exp_t model();
    exp_t e;
    logic signed [67:0] a, b, c, d, rs, vs, k, rt;
    logic st, cont;
    a = x1;  a = a - x2;
    b = y1;  b = b - y2;
    c = vx1; c = c - vx2;
    d = vy1; d = d - vy2;
    rt = {36'd0, r2};
    rs = a*a + b*b;
    vs = c*c + d*d;
    k  = a*c + b*d;
    st = (rs < rt);
    if (!mode || vs == 0) cont = st;
    else cont = (rs*vs - k*k < vs*rt);
    e.hit_nm = mode ? cont : st;
    e.hit    = mode ? (cont && (k < 0 || st)) : st;
    e.appr   = (k < 0);
    e.sep    = rs[33:0];
    e.due    = 0;
    return e;
  endfunction

  // Entered and left on a falling edge; waits (bounded) for the DUT to be free.
  task automatic applyStimulus(input int px1, input int py1, input int px2, input int py2,
                               input int pvx1, input int pvy1, input int pvx2, input int pvy2,
                               input logic [31:0] pr2, input logic pmode);
    exp_t e;
    int guard = 0;
    while (busy && guard < 40) begin
      @(negedge clock);
      guard++;
    end
    checkOutput("wait_idle", busy, 1'b0);
    x1 = 16'(px1);  y1 = 16'(py1);  x2 = 16'(px2);  y2 = 16'(py2);
    vx1 = 16'(pvx1); vy1 = 16'(pvy1); vx2 = 16'(pvx2); vy2 = 16'(pvy2);
    r2 = pr2; mode = pmode; in_rdy = 1'b1;
    e = model();
    @(posedge clock);
    #1;
    e.due = cyc + 12;
    sb.push_back(e);
    checkOutput("accept_busy", busy, 1'b1);
    @(negedge clock);
    in_rdy = 1'b0;
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (reset_n && out_rdy) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_out_rdy", out_rdy, 1'b0);
      end else begin
        e = sb.pop_front();
        checkOutput("latency", cyc, e.due);
        checkOutput("hit", hit, e.hit);
        checkOutput("hit_nomask", hit_nm, e.hit_nm);
        checkOutput("approaching", approaching, e.appr);
        checkOutput("sep_sq", sep_sq, e.sep);
        checkOutput("busy_at_done", busy, 1'b0);
      end
    end
  end

  initial begin
    int guard;
    repeat (3) @(negedge clock);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_out_rdy", out_rdy, 1'b0);
    checkOutput("rst_hit", hit, 1'b0);
    checkOutput("rst_appr", approaching, 1'b0);
    checkOutput("rst_sep", sep_sq, 34'd0);

    // Request presented on the very first edge out of reset.
    reset_n = 1'b1;
    applyStimulus(0, 0, 10, 0, 1, 0, -1, 0, 32'd4, 1'b1);
    applyStimulus(0, 0, 0, 10, 1, 0, 1, 0, 32'd4, 1'b1);
    applyStimulus(0, 0, 10, 0, -1, 0, 1, 0, 32'd4, 1'b1);
    applyStimulus(-1, -1, 0, 0, 0, 0, 0, 0, 32'd4, 1'b0);
    applyStimulus(-3, 0, 0, 0, 0, 0, 0, 0, 32'd9, 1'b0);
    applyStimulus(-3, 0, 0, 0, 0, 0, 0, 0, 32'd9, 1'b1);
    applyStimulus(-32768, 32767, 32767, -32768, 32767, -32768, -32768, 32767, 32'hFFFF_FFFF, 1'b1);

    // Busy drop, then a request in the out_rdy cycle.
    applyStimulus(5, 5, -5, -5, -1, -1, 1, 1, 32'd50, 1'b1);
    repeat (4) @(negedge clock);
    x1 = 16'd100; r2 = 32'd1; mode = 1'b0; in_rdy = 1'b1;
    @(negedge clock);
    in_rdy = 1'b0;
    checkOutput("drop_busy", busy, 1'b1);
    guard = 0;
    while (!out_rdy && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    checkOutput("drop_out_rdy_seen", out_rdy, 1'b1);
    applyStimulus(3, 4, 0, 0, 0, 0, 0, 0, 32'd30, 1'b0);

    // Reset six cycles after acceptance aborts the request.
    applyStimulus(0, 0, 20, 0, 2, 0, -2, 0, 32'd16, 1'b1);
    repeat (5) @(negedge clock);
    reset_n = 1'b0;
    sb.delete();
    @(negedge clock);
    reset_n = 1'b1;
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_out_rdy", out_rdy, 1'b0);
    checkOutput("abort_hit", hit, 1'b0);
    checkOutput("abort_appr", approaching, 1'b0);
    checkOutput("abort_sep", sep_sq, 34'd0);
    repeat (15) @(negedge clock);
    applyStimulus(0, 0, 20, 0, 2, 0, -2, 0, 32'd16, 1'b1);

    for (int i = 0; i < 10; i++) begin
      if (i < 7)
        applyStimulus(int'($urandom_range(40)) - 20, int'($urandom_range(40)) - 20,
                      int'($urandom_range(40)) - 20, int'($urandom_range(40)) - 20,
                      int'($urandom_range(6)) - 3, int'($urandom_range(6)) - 3,
                      int'($urandom_range(6)) - 3, int'($urandom_range(6)) - 3,
                      32'($urandom_range(900)), 1'($urandom_range(1)));
      else
        applyStimulus(int'($urandom), int'($urandom), int'($urandom), int'($urandom),
                      int'($urandom), int'($urandom), int'($urandom), int'($urandom),
                      $urandom, 1'($urandom_range(1)));
    end

    guard = 0;
    while (sb.size() != 0 && guard < 40) begin
      @(negedge clock);
      guard++;
    end
    checkOutput("drain", sb.size(), 0);
    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
